// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter with a one-word pending
// buffer, an offer/ready handshake per word and a clock enable.
// Optional build macro SERIAL_TX_MSB_FIRST_EN: when defined, bits go out MSB
// first; otherwise LSB first. Only bit order changes with the macro.
module serial_word_tx #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    output logic                  o_dout_valid,
    input  logic                  i_ready,
    output logic                  o_dout
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [DATA_WIDTH-1:0] pend;
    logic [DATA_WIDTH-1:0] pend_n;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;
    logic                  word_ready_n;
    logic                  dout_valid_n;
    logic                  dout_n;

    logic                  head_bit;
    logic [DATA_WIDTH-1:0] shreg_adv;

    // Next bit to transmit and the shift register after consuming it.
`ifdef SERIAL_TX_MSB_FIRST_EN
    always_comb begin
        head_bit  = shreg[DATA_WIDTH-1];
        shreg_adv = {shreg[DATA_WIDTH-2:0], 1'b0};
    end
`else
    always_comb begin
        head_bit  = shreg[0];
        shreg_adv = {1'b0, shreg[DATA_WIDTH-1:1]};
    end
`endif

    // Next-state and registered-output computation; everything holds when i_en is low.
    always_comb begin
        state_n      = state;
        pend_n       = pend;
        shreg_n      = shreg;
        cnt_n        = cnt;
        word_ready_n = o_word_ready;
        dout_valid_n = o_dout_valid;
        dout_n       = o_dout;

        if (i_en) begin
            // o_word_ready doubles as the pending-empty flag, so accept and
            // drain can never hit the buffer on the same edge.
            if (i_word_valid && o_word_ready) begin
                pend_n       = i_word;
                word_ready_n = 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!o_word_ready) begin
                        shreg_n      = pend;
                        word_ready_n = 1'b1;
                        dout_valid_n = 1'b1;
                        state_n      = ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (i_ready) begin
                        dout_valid_n = 1'b0;
                        cnt_n        = '0;
                        dout_n       = head_bit;
                        shreg_n      = shreg_adv;
                        state_n      = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        dout_n = 1'b0;
                        cnt_n  = '0;
                        if (!o_word_ready) begin
                            shreg_n      = pend;
                            word_ready_n = 1'b1;
                            dout_valid_n = 1'b1;
                            state_n      = ST_OFFER;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        dout_n  = head_bit;
                        shreg_n = shreg_adv;
                    end
                end
                default: begin
                    state_n      = ST_IDLE;
                    dout_valid_n = 1'b0;
                    dout_n       = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset wins over the enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            pend         <= '0;
            shreg        <= '0;
            cnt          <= '0;
            o_word_ready <= 1'b1;
            o_dout_valid <= 1'b0;
            o_dout       <= 1'b0;
        end else begin
            state        <= state_n;
            pend         <= pend_n;
            shreg        <= shreg_n;
            cnt          <= cnt_n;
            o_word_ready <= word_ready_n;
            o_dout_valid <= dout_valid_n;
            o_dout       <= dout_n;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx: directed scenarios plus randomized traffic,
// checked by a scoreboard queue of accepted words and a serial-bit monitor.
module tb_serial_word_tx;

    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic [W-1:0] i_word;
    logic         i_word_valid;
    logic         o_word_ready;
    logic         o_dout_valid;
    logic         i_ready;
    logic         o_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    bit           mon_collecting = 1'b0;
    int           mon_idx = 0;
    int           mon_cycles = 0;
    int           last_shift_cycles = 0;
    int           words_done = 0;
    logic [W-1:0] mon_cap;
    logic [W-1:0] mon_exp;

    serial_word_tx #(.DATA_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .o_dout       (o_dout)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: at each falling edge, capture serial bits after a handshake and
    // compare the reassembled word with the oldest accepted word.
    always @(negedge clk) begin
        if (i_rst) begin
            exp_q.delete();
            mon_collecting = 1'b0;
        end else begin
            if (mon_collecting) begin
`ifdef SERIAL_TX_MSB_FIRST_EN
                mon_cap[W-1-mon_idx] = o_dout;
`else
                mon_cap[mon_idx] = o_dout;
`endif
                mon_cycles++;
                if (i_en) begin
                    mon_idx++;
                    if (mon_idx == W) begin
                        mon_collecting = 1'b0;
                        check("word_bits", 64'(mon_cap), 64'(mon_exp));
                        last_shift_cycles = mon_cycles;
                        words_done++;
                    end
                end
            end else begin
                check("dout_zero_outside_shift", 64'(o_dout), 64'd0);
            end
            if (!mon_collecting && i_en && o_dout_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_offer: got offer expected none queued");
                    mon_exp = '0;
                end else begin
                    mon_exp = exp_q.pop_front();
                end
                mon_collecting = 1'b1;
                mon_idx        = 0;
                mon_cycles     = 0;
                mon_cap        = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int t = 0;
        while (!o_word_ready && t < 500) begin
            tick();
            t++;
        end
        if (!o_word_ready) begin
            check("send_ready_timeout", 64'(o_word_ready), 64'd1);
        end else begin
            i_word       = w;
            i_word_valid = 1'b1;
            exp_q.push_back(w);
            tick();
            i_word_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        i_ready = 1'b1;
        i_en    = 1'b1;
        while ((exp_q.size() != 0 || mon_collecting) && t < 5000) begin
            tick();
            t++;
        end
        check("drain_done", 64'(exp_q.size() == 0 && !mon_collecting), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        bit bad_v, bad_d, bad_r, seen;
        int n, t, sent;

        i_rst = 1'b1; i_en = 1'b1; i_word = '0; i_word_valid = 1'b0; i_ready = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        check("reset_dout", 64'(o_dout), 64'd0);
        check("reset_dout_valid", 64'(o_dout_valid), 64'd0);
        check("reset_word_ready", 64'(o_word_ready), 64'd1);

        // Offer latency and the reference bit sequence of A5C3F0.
        send_word(24'hA5C3F0);
        check("offer_after_1_edge", 64'(o_dout_valid), 64'd0);
        tick();
        check("offer_after_2_edges", 64'(o_dout_valid), 64'd1);
        i_ready = 1'b1;
        tick();
        got = '0;
        for (int k = 0; k < W; k++) begin
`ifdef SERIAL_TX_MSB_FIRST_EN
            got[W-1-k] = o_dout;
`else
            got[k] = o_dout;
`endif
            tick();
        end
        check("a5c3f0_sequence", 64'(got), 64'hA5C3F0);
        drain();

        // Long back-pressure while offered, with the pending buffer full.
        i_ready = 1'b0;
        send_word(24'h123456);
        send_word(24'h654321);
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_dout_valid !== 1'b1) bad_v = 1;
            if (o_dout !== 1'b0) bad_d = 1;
            if (o_word_ready !== 1'b0) bad_r = 1;
            tick();
        end
        check("stall_valid_held", 64'(bad_v), 64'd0);
        check("stall_dout_zero", 64'(bad_d), 64'd0);
        check("stall_ready_low", 64'(bad_r), 64'd0);
        drain();

        // Back-to-back words: second is offered right after the 24th bit.
        i_ready = 1'b1;
        send_word(24'h000001);
        send_word(24'h800000);
        n = words_done; t = 0;
        while (words_done == n && t < 200) begin
            tick();
            t++;
        end
        check("no_idle_gap", 64'(o_dout_valid), 64'd1);
        drain();

        // Enable low for 3 cycles at bit 5 stretches that bit.
        i_ready = 1'b1;
        send_word(24'hFFFFFF);
        tick();
        check("ffffff_offered", 64'(o_dout_valid), 64'd1);
        tick();
        repeat (5) tick();
        i_en = 1'b0;
        repeat (3) tick();
        i_en = 1'b1;
        drain();
        check("shift_cycles_stretched", 64'(last_shift_cycles), 64'd27);

        // Reset at bit 10 discards the shifting and pending words.
        i_ready = 1'b1;
        send_word(24'h5A5A5A);
        send_word(24'hC0FFEE);
        repeat (10) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rst_mid_dout", 64'(o_dout), 64'd0);
        check("rst_mid_dout_valid", 64'(o_dout_valid), 64'd0);
        check("rst_mid_word_ready", 64'(o_word_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            if (o_dout_valid) seen = 1;
            tick();
        end
        check("pending_discarded", 64'(seen), 64'd0);

        // Randomized traffic with random enable and back-pressure.
        sent = 0;
        for (int c = 0; c < 6000 && sent < 80; c++) begin
            i_en    = ($urandom_range(0, 7) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            if (o_word_ready && $urandom_range(0, 1) == 1) begin
                i_word       = W'({$urandom(), $urandom()});
                i_word_valid = 1'b1;
                if (i_en) begin
                    exp_q.push_back(i_word);
                    sent++;
                end
            end else begin
                i_word_valid = 1'b0;
            end
            tick();
        end
        i_word_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
